rom_load_sequencer: RTL

Controls the ROM download path between the HPS `ioctl` interface and the arcade core's ROM/PROM write ports. It decodes each downloaded byte into a program, graphics or colour-PROM region and drives that region's write strobe. It keeps a byte count and an additive checksum. It holds the core in reset until a complete, correctly sized image has loaded and a post-load settling delay has elapsed. It sits between `hps_io` and the `pacman` core and replaces the direct `ioctl_download` term in the core reset.

---
 rtl/rom_load_sequencer.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer
// Sits between hps_io and the arcade core. It steers each downloaded ioctl
// byte to the program, graphics or colour-PROM write port, keeps a byte count
// and a 16-bit additive checksum, and holds the core in reset until a
// correctly sized image has loaded and a settling delay has elapsed.
//
// Ports:
//   clk_sys         system clock, rising edge
//   RESET_N         asynchronous active-low reset
//   ioctl_download  download window from hps_io
//   ioctl_wr        one-cycle byte strobe
//   ioctl_addr      byte offset within the image
//   ioctl_dout      byte data
//   rom_addr        region-relative address of the byte being written
//   rom_data        byte being written
//   we_prog/gfx/prom  one-cycle region write strobes (mutually exclusive)
//   core_reset      active-high reset to the core
//   load_done       a valid image is loaded and the core is running
//   load_error      last download had the wrong length (sticky until next rise)
//   checksum        mod-2^16 sum of in-range bytes of the last/current download
module rom_load_sequencer #(
  parameter int PROG_SIZE   = 16384,
  parameter int GFX_SIZE    = 8192,
  parameter int PROM_SIZE   = 512,
  parameter int HOLD_CYCLES = 64
) (
  input  logic        clk_sys,
  input  logic        RESET_N,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        we_prog,
  output logic        we_gfx,
  output logic        we_prom,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_error,
  output logic [15:0] checksum
);

  localparam int TOTAL = PROG_SIZE + GFX_SIZE + PROM_SIZE;

  localparam logic [24:0] GFX_BASE  = 25'(PROG_SIZE);
  localparam logic [24:0] PROM_BASE = 25'(PROG_SIZE + GFX_SIZE);
  localparam logic [24:0] END_ADDR  = 25'(TOTAL);
  localparam logic [25:0] TOTAL_CNT = 26'(TOTAL);
  localparam logic [25:0] CNT_MAX   = {26{1'b1}};
  localparam logic [25:0] CNT_ONE   = 26'd1;

  localparam int HOLD_W = $clog2(HOLD_CYCLES) + 2;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_RUN  = 2'd3;

  // State registers
  logic [1:0]        state_r;
  logic              dl_q;
  logic [HOLD_W-1:0] hold_r;
  logic [25:0]       cnt_r;
  logic [15:0]       sum_r;
  logic              err_r;
  logic              done_r;
  logic              crst_r;
  logic              we_prog_r;
  logic              we_gfx_r;
  logic              we_prom_r;
  logic [15:0]       rom_addr_r;
  logic [7:0]        rom_data_r;

  // Next-state values
  logic [1:0]        state_nxt_s;
  logic [HOLD_W-1:0] hold_nxt_s;
  logic [25:0]       cnt_nxt_s;
  logic [15:0]       sum_nxt_s;
  logic              err_nxt_s;
  logic              done_nxt_s;
  logic              crst_nxt_s;
  logic              we_prog_nxt_s;
  logic              we_gfx_nxt_s;
  logic              we_prom_nxt_s;
  logic [15:0]       addr_nxt_s;
  logic [7:0]        data_nxt_s;

  logic rise_s;
  logic fall_s;
  logic accept_s;

  assign rise_s = ioctl_download & ~dl_q;
  assign fall_s = ~ioctl_download & dl_q;
  // A write on the rise cycle is taken even though the state is not LOAD yet;
  // a write on the fall cycle is taken because the state is still LOAD.
  assign accept_s = ioctl_wr & (rise_s | (state_r == ST_LOAD));

  // Next-state logic: load entry, byte steering/counting, then FSM progress
  always_comb begin
    state_nxt_s   = state_r;
    hold_nxt_s    = hold_r;
    cnt_nxt_s     = cnt_r;
    sum_nxt_s     = sum_r;
    err_nxt_s     = err_r;
    done_nxt_s    = done_r;
    crst_nxt_s    = crst_r;
    we_prog_nxt_s = 1'b0;
    we_gfx_nxt_s  = 1'b0;
    we_prom_nxt_s = 1'b0;
    addr_nxt_s    = rom_addr_r;
    data_nxt_s    = rom_data_r;

    // Entry actions come first so a byte on the rise cycle lands on a clean
    // count and checksum.
    if (rise_s) begin
      cnt_nxt_s  = 26'd0;
      sum_nxt_s  = 16'd0;
      err_nxt_s  = 1'b0;
      done_nxt_s = 1'b0;
      crst_nxt_s = 1'b1;
    end else begin
      cnt_nxt_s  = cnt_r;
    end

    if (accept_s) begin
      if (cnt_nxt_s != CNT_MAX) begin
        cnt_nxt_s = cnt_nxt_s + CNT_ONE;
      end else begin
        cnt_nxt_s = CNT_MAX;
      end

      if (ioctl_addr < GFX_BASE) begin
        we_prog_nxt_s = 1'b1;
        addr_nxt_s    = 16'(ioctl_addr);
        data_nxt_s    = ioctl_dout;
        sum_nxt_s     = sum_nxt_s + {8'd0, ioctl_dout};
      end else if (ioctl_addr < PROM_BASE) begin
        we_gfx_nxt_s  = 1'b1;
        addr_nxt_s    = 16'(ioctl_addr - GFX_BASE);
        data_nxt_s    = ioctl_dout;
        sum_nxt_s     = sum_nxt_s + {8'd0, ioctl_dout};
      end else if (ioctl_addr < END_ADDR) begin
        we_prom_nxt_s = 1'b1;
        addr_nxt_s    = 16'(ioctl_addr - PROM_BASE);
        data_nxt_s    = ioctl_dout;
        sum_nxt_s     = sum_nxt_s + {8'd0, ioctl_dout};
      end else begin
        // Past the image end: counted for the length check, never written.
        addr_nxt_s    = rom_addr_r;
      end
    end else begin
      addr_nxt_s = rom_addr_r;
    end

    if (rise_s) begin
      state_nxt_s = ST_LOAD;
    end else begin
      case (state_r)
        ST_IDLE: begin
          crst_nxt_s = 1'b1;
        end
        ST_LOAD: begin
          // Length check uses the count including a byte on the fall cycle.
          if (fall_s) begin
            if (cnt_nxt_s == TOTAL_CNT) begin
              state_nxt_s = ST_HOLD;
              hold_nxt_s  = HOLD_LOAD;
            end else begin
              state_nxt_s = ST_IDLE;
              err_nxt_s   = 1'b1;
            end
          end else begin
            state_nxt_s = ST_LOAD;
          end
        end
        ST_HOLD: begin
          crst_nxt_s = 1'b1;
          if (hold_r == HOLD_ZERO) begin
            state_nxt_s = ST_RUN;
            crst_nxt_s  = 1'b0;
            done_nxt_s  = 1'b1;
          end else begin
            hold_nxt_s  = hold_r - HOLD_ONE;
          end
        end
        ST_RUN: begin
          crst_nxt_s = 1'b0;
          done_nxt_s = 1'b1;
        end
        default: begin
          state_nxt_s = ST_IDLE;
          crst_nxt_s  = 1'b1;
          done_nxt_s  = 1'b0;
        end
      endcase
    end
  end

  // Register all state and outputs
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r    <= ST_IDLE;
      // Starts high so a download already open when reset lifts is not taken
      // as a rise; a fresh rise is needed to begin a load.
      dl_q       <= 1'b1;
      hold_r     <= HOLD_ZERO;
      cnt_r      <= 26'd0;
      sum_r      <= 16'd0;
      err_r      <= 1'b0;
      done_r     <= 1'b0;
      crst_r     <= 1'b1;
      we_prog_r  <= 1'b0;
      we_gfx_r   <= 1'b0;
      we_prom_r  <= 1'b0;
      rom_addr_r <= 16'd0;
      rom_data_r <= 8'd0;
    end else begin
      state_r    <= state_nxt_s;
      dl_q       <= ioctl_download;
      hold_r     <= hold_nxt_s;
      cnt_r      <= cnt_nxt_s;
      sum_r      <= sum_nxt_s;
      err_r      <= err_nxt_s;
      done_r     <= done_nxt_s;
      crst_r     <= crst_nxt_s;
      we_prog_r  <= we_prog_nxt_s;
      we_gfx_r   <= we_gfx_nxt_s;
      we_prom_r  <= we_prom_nxt_s;
      rom_addr_r <= addr_nxt_s;
      rom_data_r <= data_nxt_s;
    end
  end

  assign rom_addr   = rom_addr_r;
  assign rom_data   = rom_data_r;
  assign we_prog    = we_prog_r;
  assign we_gfx     = we_gfx_r;
  assign we_prom    = we_prom_r;
  assign core_reset = crst_r;
  assign load_done  = done_r;
  assign load_error = err_r;
  assign checksum   = sum_r;

endmodule
